psm_sequencer: RTL

- Start/stop/fault sequencer sitting in front of the PSM gate-pattern controller of the DAB converter.
- Owns the controller's reset and the gate-enable qualifier.
- Latches frequency and deadtime at start.
- Soft-ramps SPS/DPS phase shifts from zero to target and back, one slew step per switching period.
- Forces gates off on fault or on a missing period tick.

---
 rtl/psm_pkg.sv | 35 +++
 rtl/psm_slew_limiter.sv | 48 ++++
 rtl/psm_sequencer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/psm_pkg.sv
// psm_pkg: shared types and helpers for the PSM start/stop sequencer.
// State codes, data widths and sign-magnitude conversions.
package psm_pkg;

    localparam int BITS_DATA = 16;
    localparam int DT_BITS   = 7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_RAMP  = 3'd2,
        ST_RUN   = 3'd3,
        ST_STOP  = 3'd4,
        ST_FAULT = 3'd5
    } psm_state_t;

    // Negative zero folds to 0 because -0 == 0.
    function automatic logic signed [BITS_DATA:0] sm_to_tc(
        input logic [BITS_DATA-1:0] sm
    );
        logic signed [BITS_DATA:0] mag;
        mag = {2'b00, sm[BITS_DATA-2:0]};
        return sm[BITS_DATA-1] ? -mag : mag;
    endfunction

    // A negative value is never zero, so 0 always maps to 0x0000.
    function automatic logic [BITS_DATA-1:0] tc_to_sm(
        input logic signed [BITS_DATA:0] tc
    );
        logic [BITS_DATA:0] mag;
        mag = tc[BITS_DATA] ? -tc : tc;
        return {tc[BITS_DATA], mag[BITS_DATA-2:0]};
    endfunction

endpackage

// File: rtl/psm_slew_limiter.sv
// psm_slew_limiter: tick-gated rate limiter on a signed phase word.
// Moves toward target by at most step per enable; step 0 loads directly.
module psm_slew_limiter
    import psm_pkg::*;
(
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic                        clr,
    input  logic                        en,
    input  logic signed [BITS_DATA:0]   target,
    input  logic signed [BITS_DATA:0]   step,
    output logic signed [BITS_DATA:0]   cur,
    output logic signed [BITS_DATA:0]   nxt
);

    logic signed [BITS_DATA+1:0] diff;
    logic signed [BITS_DATA+1:0] adiff;
    logic signed [BITS_DATA+1:0] step_x;

    // Next value: clear, hold, snap to target, or one bounded step.
    always_comb begin
        diff   = {target[BITS_DATA], target} - {cur[BITS_DATA], cur};
        adiff  = diff[BITS_DATA+1] ? -diff : diff;
        step_x = {step[BITS_DATA], step};
        nxt    = cur;
        if (clr) begin
            nxt = '0;
        end else if (en) begin
            if (step == '0 || adiff <= step_x) begin
                nxt = target;
            end else if (diff[BITS_DATA+1]) begin
                nxt = cur - step;
            end else begin
                nxt = cur + step;
            end
        end
    end

    // Current phase register.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            cur <= '0;
        end else begin
            cur <= nxt;
        end
    end

endmodule

// File: rtl/psm_sequencer.sv
// psm_sequencer: start/stop/fault sequencer ahead of the DAB PSM controller.
// Owns PSM reset, gate enable, phase soft-ramp and the period watchdog.
module psm_sequencer
    import psm_pkg::*;
#(
    parameter int ARM_CYCLES = 16,
    parameter int MIN_FREQ   = 8
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    iEnable,
    input  logic                    iFault,
    input  logic                    iFaultClear,
    input  logic                    iPeriodTick,
    input  logic [BITS_DATA-1:0]    iSPS,
    input  logic [BITS_DATA-1:0]    iDPS,
    input  logic [BITS_DATA-1:0]    iFREQUENCY,
    input  logic [DT_BITS-1:0]      iDEADTIME,
    input  logic [BITS_DATA-2:0]    iRampStep,
    output logic                    oPSM_rst,
    output logic                    oGateEn,
    output logic [BITS_DATA-1:0]    oSPS,
    output logic [BITS_DATA-1:0]    oDPS,
    output logic [BITS_DATA-1:0]    oFREQUENCY,
    output logic [DT_BITS-1:0]      oDEADTIME,
    output logic [2:0]              oState,
    output logic                    oRampDone,
    output logic                    oFaultLatched
);

    localparam int ARM_W = $clog2(ARM_CYCLES + 1);

    psm_state_t state;
    psm_state_t state_nxt;

    logic [ARM_W-1:0]         arm_cnt;
    logic [BITS_DATA:0]       wd_cnt;
    logic [BITS_DATA-1:0]     freq_q;
    logic [DT_BITS-1:0]       dt_q;
    logic [BITS_DATA-2:0]     half;
    logic [BITS_DATA-2:0]     sps_mag;
    logic [BITS_DATA-1:0]     dps_clip;

    logic signed [BITS_DATA:0] sps_tgt_in;
    logic signed [BITS_DATA:0] dps_tgt_in;
    logic signed [BITS_DATA:0] sps_tgt_sel;
    logic signed [BITS_DATA:0] dps_tgt_sel;
    logic signed [BITS_DATA:0] sps_tgt_q;
    logic signed [BITS_DATA:0] dps_tgt_q;
    logic signed [BITS_DATA:0] sps_tgt_d;
    logic signed [BITS_DATA:0] dps_tgt_d;
    logic signed [BITS_DATA:0] step_s;
    logic signed [BITS_DATA:0] sps_cur;
    logic signed [BITS_DATA:0] sps_nxt;
    logic signed [BITS_DATA:0] dps_cur;
    logic signed [BITS_DATA:0] dps_nxt;

    logic tgt_vld;
    logic tgt_vld_d;
    logic freq_ok;
    logic arm_last;
    logic active;
    logic active_nxt;
    logic wd_trip;
    logic fault_trip;
    logic at_tgt;
    logic at_zero;
    logic slew_en;
    logic slew_clr;
    logic ramp_done_d;

    assign freq_ok    = iFREQUENCY >= BITS_DATA'(MIN_FREQ);
    assign arm_last   = arm_cnt == ARM_W'(ARM_CYCLES - 1);
    assign active     = state inside {ST_RAMP, ST_RUN, ST_STOP};
    assign active_nxt = state_nxt inside {ST_RAMP, ST_RUN, ST_STOP};
    assign wd_trip    = active && (wd_cnt == {freq_q, 1'b0});
    assign fault_trip = iFault || wd_trip;
    assign at_tgt     = tgt_vld && (sps_cur == sps_tgt_q)
                        && (dps_cur == dps_tgt_q);
    assign at_zero    = (sps_cur == '0) && (dps_cur == '0);
    assign step_s     = {2'b00, iRampStep};
    assign oState     = state;
    assign oFREQUENCY = freq_q;
    assign oDEADTIME  = dt_q;

    // Targets: sign-magnitude to two's complement, clamped to half period.
    always_comb begin
        half     = freq_q[BITS_DATA-1:1];
        sps_mag  = (iSPS[BITS_DATA-2:0] > half) ? half : iSPS[BITS_DATA-2:0];
        dps_clip = (iDPS > {1'b0, half}) ? {1'b0, half} : iDPS;
        sps_tgt_in = sm_to_tc({iSPS[BITS_DATA-1], sps_mag});
        dps_tgt_in = {1'b0, dps_clip};
        sps_tgt_sel = (state == ST_STOP) ? '0 : sps_tgt_in;
        dps_tgt_sel = (state == ST_STOP) ? '0 : dps_tgt_in;
    end

    // Next state; a fault or watchdog trip overrides every other event.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:
                if (iEnable && !oFaultLatched && freq_ok)
                    state_nxt = ST_ARM;
            ST_ARM:
                if (!iEnable)      state_nxt = ST_IDLE;
                else if (arm_last) state_nxt = ST_RAMP;
            ST_RAMP:
                if (!iEnable)    state_nxt = ST_STOP;
                else if (at_tgt) state_nxt = ST_RUN;
            ST_RUN:
                if (!iEnable) state_nxt = ST_STOP;
            ST_STOP:
                if (iEnable)      state_nxt = ST_RAMP;
                else if (at_zero) state_nxt = ST_IDLE;
            ST_FAULT:
                if (iFaultClear && !iEnable && !iFault)
                    state_nxt = ST_IDLE;
            default:
                state_nxt = ST_FAULT;
        endcase
        if (fault_trip) state_nxt = ST_FAULT;
    end

    // Slew only on a tick where no transition happens this cycle.
    always_comb begin
        slew_en   = iPeriodTick && active && (state_nxt == state);
        slew_clr  = !active_nxt;
        sps_tgt_d = slew_en ? sps_tgt_in : sps_tgt_q;
        dps_tgt_d = slew_en ? dps_tgt_in : dps_tgt_q;
        tgt_vld_d = !slew_clr && (slew_en || tgt_vld);
        ramp_done_d = (state_nxt == ST_RUN) && tgt_vld_d
                      && (sps_nxt == sps_tgt_d) && (dps_nxt == dps_tgt_d);
    end

    psm_slew_limiter u_sps (
        .clk    (clk),
        .n_rst  (n_rst),
        .clr    (slew_clr),
        .en     (slew_en),
        .target (sps_tgt_sel),
        .step   (step_s),
        .cur    (sps_cur),
        .nxt    (sps_nxt)
    );

    psm_slew_limiter u_dps (
        .clk    (clk),
        .n_rst  (n_rst),
        .clr    (slew_clr),
        .en     (slew_en),
        .target (dps_tgt_sel),
        .step   (step_s),
        .cur    (dps_cur),
        .nxt    (dps_nxt)
    );

    // State register, latched settings, timers and registered outputs.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state         <= ST_IDLE;
            arm_cnt       <= '0;
            wd_cnt        <= '0;
            freq_q        <= '0;
            dt_q          <= '0;
            sps_tgt_q     <= '0;
            dps_tgt_q     <= '0;
            tgt_vld       <= 1'b0;
            oPSM_rst      <= 1'b1;
            oGateEn       <= 1'b0;
            oSPS          <= '0;
            oDPS          <= '0;
            oRampDone     <= 1'b0;
            oFaultLatched <= 1'b0;
        end else begin
            state     <= state_nxt;
            sps_tgt_q <= sps_tgt_d;
            dps_tgt_q <= dps_tgt_d;
            tgt_vld   <= tgt_vld_d;
            if (state == ST_IDLE && state_nxt == ST_ARM) begin
                freq_q <= iFREQUENCY;
                dt_q   <= iDEADTIME;
            end
            if (state == ST_ARM && state_nxt == ST_ARM)
                arm_cnt <= arm_cnt + 1'b1;
            else
                arm_cnt <= '0;
            if (!active || iPeriodTick)
                wd_cnt <= {{BITS_DATA{1'b0}}, 1'b1};
            else
                wd_cnt <= wd_cnt + 1'b1;
            oPSM_rst      <= !active_nxt;
            oGateEn       <= active_nxt;
            oSPS          <= tc_to_sm(sps_nxt);
            oDPS          <= dps_nxt[BITS_DATA-1:0];
            oRampDone     <= ramp_done_d;
            oFaultLatched <= (state_nxt == ST_FAULT);
        end
    end

endmodule
